wb_gpio_bank: RTL
=================

Name: wb_gpio_bank

Overview:
Parametrised Wishbone GPIO controller. It replaces the fixed pair of 8-bit gpioA/gpioB ports with NPORTS ports of WIDTH bits each. Each port adds:
- per-pin output enable
- input synchroniser
- rising/falling edge detection
- maskable, sticky interrupt-pending register
- atomic output toggle

It sits on the SoC peripheral Wishbone bus. The pin-level i/o/oe triplets go to the top level, which handles tristate or sim.

Parameters:
NPORTS, 2, number of GPIO ports; 1..8.
WIDTH, 8, pins per port; 1..32.
SYNC_STAGES, 2, input synchroniser flops; 2..4.
PORT_AW, 3, port-index address bits; must satisfy 2**PORT_AW >= NPORTS.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_wb_adr  in  PORT_AW+5  byte address; [4:2] register, [PORT_AW+4:5] port index
i_wb_dat  in  32  write data
i_wb_sel  in  4  byte lane enables
i_wb_we  in  1  write strobe
i_wb_cyc  in  1  bus cycle
i_wb_stb  in  1  strobe
o_wb_rdt  out  32  read data
o_wb_ack  out  1  acknowledge
i_gpio  in  NPORTS*WIDTH  pin inputs; port p occupies [p*WIDTH +: WIDTH]
o_gpio  out  NPORTS*WIDTH  pin output values
o_gpio_oe  out  NPORTS*WIDTH  pin output enables, 1 = drive
o_irq  out  1  OR of all enabled pending bits

Behaviour:
- Register map per port, word offsets:
  - 0x00 OUT (RW)
  - 0x04 OE (RW)
  - 0x08 IN (RO, synchronised pins)
  - 0x0C IRQ_EN (RW)
  - 0x10 RISE_EN (RW)
  - 0x14 FALL_EN (RW)
  - 0x18 PEND (read; write-1-to-clear)
  - 0x1C TOGGLE (WO; a 1 inverts the OUT bit; reads 0)
- Bits [31:WIDTH] read 0 and ignore writes. i_wb_sel gates writes per byte lane on all writable registers, including PEND and TOGGLE.
- Reset (async on i_rst_n low): o_wb_ack=0, o_wb_rdt=0, o_irq=0. All of OUT, OE, IRQ_EN, RISE_EN, FALL_EN, PEND, the synchroniser flops and the previous-sample register are 0, so o_gpio=0 and o_gpio_oe=0.
- Bus handshake:
  - Ack is registered and asserts the cycle after i_wb_cyc&i_wb_stb&!o_wb_ack, for exactly one cycle.
  - o_wb_rdt is valid in the ack cycle and is 0 when ack is low.
  - A write takes effect on the same edge that raises ack.
  - No wait states. Back-to-back accesses are spaced by the ack cycle.
- Port index >= NPORTS: ack still given, reads return 0, writes ignored.
- Input path:
  - i_gpio passes through SYNC_STAGES flops, giving IN.
  - prev <= IN every cycle.
  - rise = IN & ~prev & RISE_EN; fall = ~IN & prev & FALL_EN.
- Pending:
  - PEND <= (PEND & ~w1c_mask) | rise | fall.
  - A set event on a bit wins over a simultaneous W1C on that bit.
- Post-reset edge suppression: a per-block prime counter masks rise/fall until SYNC_STAGES+1 cycles after reset release. Pins held high through reset therefore never raise PEND.
- o_irq is registered: o_irq <= |(PEND & IRQ_EN) over all ports. It asserts 1 cycle after PEND is set.
- Latency: pin change to IN takes SYNC_STAGES cycles; PEND sets at SYNC_STAGES+1; o_irq asserts at SYNC_STAGES+2.
- TOGGLE and OUT targeting the same port cannot coincide, since the bus carries one access per ack.
- OE=0 leaves OUT retained. IN always reflects the pin, including driven pins (loopback).
- Reset mid-transaction: ack drops immediately, the write is lost, and the master must retry.

Decomposition:
- Package gpio_bank_pkg:
  - register offset localparams (REG_OUT..REG_TOGGLE)
  - data width 32
  - function for port-slice indexing
- Sub-module gpio_bank_port:
  - one port's registers, synchroniser, edge detect and PEND
  - inputs: write enable, register select, data, sel
  - outputs: read mux output, pin vectors, irq_any
- Top level:
  - generates NPORTS instances
  - decodes the port index
  - ORs/muxes read data, handles ack, prime counter and o_irq

Test Plan:
- Reset with i_gpio all 1s, release, wait 10 cycles -> PEND of every port = 0, o_irq = 0, IN = 0xFF.
- Write OE=0xF0, OUT=0xA5 to port 1 (adr 0x24, 0x20) -> o_gpio[15:8]=0xA5, o_gpio_oe[15:8]=0xF0; port 0 unchanged; each ack exactly 1 cycle after stb.
- Write TOGGLE=0x0F to port 0 with OUT=0x33 -> OUT reads 0x3C; TOGGLE reads 0.
- RISE_EN=0x01, IRQ_EN=0x01 on port 0; drive pin0 0->1 at cycle T -> PEND=0x01 at T+3, o_irq=1 at T+4; W1C 0x01 -> o_irq=0 one cycle after clear.
- FALL_EN=0x80; pin7 falls on the same cycle a W1C of 0x80 is written -> PEND bit7 stays 1.
- Access port index 5 with NPORTS=2 -> ack given, read 0, no register changes; sel=0b0001 write of 0xFFFF to OUT -> only bits [7:0] updated.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// Purpose: shared constants and helpers for the Wishbone GPIO bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_bank_pkg;

  // Bus data width.
  localparam int DW = 32;

  // Per-port register select, taken from byte address bits [4:2].
  localparam logic [2:0] REG_OUT     = 3'd0;
  localparam logic [2:0] REG_OE      = 3'd1;
  localparam logic [2:0] REG_IN      = 3'd2;
  localparam logic [2:0] REG_IRQ_EN  = 3'd3;
  localparam logic [2:0] REG_RISE_EN = 3'd4;
  localparam logic [2:0] REG_FALL_EN = 3'd5;
  localparam logic [2:0] REG_PEND    = 3'd6;
  localparam logic [2:0] REG_TOGGLE  = 3'd7;

  // LSB of port p inside a flattened NPORTS*WIDTH pin vector.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

  // Expand the four Wishbone byte-lane enables into a 32-bit bit mask.
  function automatic logic [DW-1:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_bank_port.sv
// Purpose: one GPIO port: OUT/OE/enable registers, input synchroniser,
//          edge detect, sticky pending bits. Ports: bus write side (we,
//          reg, data, mask), combinational read data, pin vectors, irq_any.
// Latency: writes land on the strobe edge; pin->IN SYNC_STAGES cycles;
//          PEND one cycle after IN. No backpressure, always accepts.
module gpio_bank_port
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_edge_en,
  input  logic             i_we,
  input  logic [2:0]       i_reg,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic [WIDTH-1:0] i_wmask,
  output logic [DW-1:0]    o_rdat,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq_any
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  logic [WIDTH-1:0] in_w;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] w1c;

  assign in_w  = sync_q[SYNC_STAGES-1];
  assign wbits = i_wdat & i_wmask;

  // Edges are gated off until the block has primed after reset, so pins
  // that were high through reset do not look like rising edges.
  assign rise = in_w & ~prev_q & rise_en_q & {WIDTH{i_edge_en}};
  assign fall = ~in_w & prev_q & fall_en_q & {WIDTH{i_edge_en}};

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    irq_en_d  = irq_en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    sync_d[0] = i_gpio;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = in_w;
    if (i_we) begin
      case (i_reg)
        REG_OUT:     out_d     = (out_q & ~i_wmask) | wbits;
        REG_OE:      oe_d      = (oe_q & ~i_wmask) | wbits;
        REG_IRQ_EN:  irq_en_d  = (irq_en_q & ~i_wmask) | wbits;
        REG_RISE_EN: rise_en_d = (rise_en_q & ~i_wmask) | wbits;
        REG_FALL_EN: fall_en_d = (fall_en_q & ~i_wmask) | wbits;
        REG_PEND:    w1c       = wbits;
        REG_TOGGLE:  out_d     = out_q ^ wbits;
        default:     ;
      endcase
    end
    // Clear first, then OR in new events: a same-cycle event survives W1C.
    pend_d = (pend_q & ~w1c) | rise | fall;
  end

  always_comb begin
    o_rdat = '0;
    case (i_reg)
      REG_OUT:     o_rdat[WIDTH-1:0] = out_q;
      REG_OE:      o_rdat[WIDTH-1:0] = oe_q;
      REG_IN:      o_rdat[WIDTH-1:0] = in_w;
      REG_IRQ_EN:  o_rdat[WIDTH-1:0] = irq_en_q;
      REG_RISE_EN: o_rdat[WIDTH-1:0] = rise_en_q;
      REG_FALL_EN: o_rdat[WIDTH-1:0] = fall_en_q;
      REG_PEND:    o_rdat[WIDTH-1:0] = pend_q;
      default:     o_rdat = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q     <= '0;
      oe_q      <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      sync_q    <= '0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      irq_en_q  <= irq_en_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      prev_q    <= prev_d;
      sync_q    <= sync_d;
    end
  end

  assign o_gpio    = out_q;
  assign o_gpio_oe = oe_q;
  assign o_irq_any = |(pend_q & irq_en_q);

endmodule

// File: rtl/wb_gpio_bank.sv
// Purpose: Wishbone GPIO bank of NPORTS x WIDTH pins. Ports: classic WB
//          slave (adr/dat/sel/we/cyc/stb -> rdt/ack), pin i/o/oe, o_irq.
// Latency: ack one cycle after strobe, no wait states; o_irq one cycle after PEND.
// Backpressure: none; one access per ack, master re-strobes after the ack cycle.
module wb_gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PORT_AW     = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [PORT_AW+4:0]        i_wb_adr,
  input  logic [31:0]               i_wb_dat,
  input  logic [3:0]                i_wb_sel,
  input  logic                      i_wb_we,
  input  logic                      i_wb_cyc,
  input  logic                      i_wb_stb,
  output logic [31:0]               o_wb_rdt,
  output logic                      o_wb_ack,
  input  logic [NPORTS*WIDTH-1:0]   i_gpio,
  output logic [NPORTS*WIDTH-1:0]   o_gpio,
  output logic [NPORTS*WIDTH-1:0]   o_gpio_oe,
  output logic                      o_irq
);

  // Every decodable port index gets a slot; slots past NPORTS read as 0.
  localparam int         NSLOT      = 2 ** PORT_AW;
  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic          ack_q, ack_d;
  logic [DW-1:0] rdt_q, rdt_d;
  logic          irq_q, irq_d;
  logic [2:0]    prime_q, prime_d;

  logic               req;
  logic               edge_en;
  logic [2:0]         reg_sel;
  logic [PORT_AW-1:0] port_idx;
  logic [DW-1:0]      lane;
  logic [DW-1:0]      slot_rdat [NSLOT];
  logic [NSLOT-1:0]   slot_irq;
  logic               unused_ok;

  // The ack_q term turns a held strobe into one access per two cycles.
  assign req      = i_wb_cyc & i_wb_stb & ~ack_q;
  assign reg_sel  = i_wb_adr[4:2];
  assign port_idx = i_wb_adr[PORT_AW+4:5];
  assign lane     = lane_mask(i_wb_sel);
  assign edge_en  = (prime_q == PRIME_DONE);

  for (genvar p = 0; p < NSLOT; p++) begin : g_slot
    if (p < NPORTS) begin : g_port
      logic wr;
      assign wr = req & i_wb_we & (port_idx == PORT_AW'(p));

      gpio_bank_port #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_port (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_edge_en (edge_en),
        .i_we      (wr),
        .i_reg     (reg_sel),
        .i_wdat    (i_wb_dat[WIDTH-1:0]),
        .i_wmask   (lane[WIDTH-1:0]),
        .o_rdat    (slot_rdat[p]),
        .i_gpio    (i_gpio[port_lsb(p, WIDTH) +: WIDTH]),
        .o_gpio    (o_gpio[port_lsb(p, WIDTH) +: WIDTH]),
        .o_gpio_oe (o_gpio_oe[port_lsb(p, WIDTH) +: WIDTH]),
        .o_irq_any (slot_irq[p])
      );
    end else begin : g_empty
      assign slot_rdat[p] = '0;
      assign slot_irq[p]  = 1'b0;
    end
  end

  always_comb begin
    ack_d   = req;
    rdt_d   = (req && !i_wb_we) ? slot_rdat[port_idx] : '0;
    irq_d   = |slot_irq;
    prime_d = edge_en ? prime_q : prime_q + 3'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q   <= 1'b0;
      rdt_q   <= '0;
      irq_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
      irq_q   <= irq_d;
      prime_q <= prime_d;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_irq    = irq_q;

  // Byte-offset bits and data/lane bits above WIDTH have no destination.
  assign unused_ok = ^{i_wb_adr[1:0], i_wb_dat, lane};

endmodule
